// File: rtl/data_memory.sv
// rtl/data_memory.sv - multi-cycle little-endian RV32I data memory with busywait handshake
// Optional MISALIGN_TRAP_EN adds a MISALIGNED flag and suppresses misaligned accesses.
module data_memory #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        MEM_READ,
    input  logic        MEM_WRITE,
    input  logic [2:0]  FUNCT3,
    input  logic [31:0] ADDRESS,
    input  logic [31:0] WRITE_DATA,
    output logic [31:0] READ_DATA,
    output logic        BUSYWAIT
`ifdef MISALIGN_TRAP_EN
    ,
    output logic        MISALIGNED
`endif
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t          state;
    logic [3:0]      count;
    logic [AW+1:0]   addr_q;
    logic [31:0]     wdata_q;
    logic [2:0]      f3_q;
    logic            wr_q;
    logic [31:0]     mem [DEPTH_WORDS];

    logic [AW-1:0]   idx;
    logic [31:0]     cur_word;
    logic [31:0]     byte_shift;
    logic [15:0]     half_sel;
    logic [31:0]     load_data;
    logic [31:0]     new_word;
    logic            store_ok;
    logic            trap;
    logic            unused_addr;

    // Address bits above the array size wrap around and are never used.
    assign unused_addr = ^ADDRESS[31:AW+2];

    assign idx        = addr_q[AW+1:2];
    assign cur_word   = mem[idx];
    assign byte_shift = cur_word >> {addr_q[1:0], 3'b000};
    assign half_sel   = addr_q[1] ? cur_word[31:16] : cur_word[15:0];

`ifdef MISALIGN_TRAP_EN
    assign trap = ((f3_q[1:0] == 2'b01) && addr_q[0]) ||
                  ((f3_q == 3'b010) && (addr_q[1:0] != 2'b00));
`else
    assign trap = 1'b0;
`endif

    always_comb begin
        load_data = 32'h0;
        case (f3_q)
            3'b000:  load_data = {{24{byte_shift[7]}}, byte_shift[7:0]};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b010:  load_data = cur_word;
            3'b100:  load_data = {24'h0, byte_shift[7:0]};
            3'b101:  load_data = {16'h0, half_sel};
            default: load_data = 32'h0;
        endcase
        if (trap) load_data = 32'h0;
    end

    always_comb begin
        new_word = cur_word;
        store_ok = 1'b1;
        case (f3_q)
            3'b000:  new_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            3'b001: begin
                if (addr_q[1]) new_word[31:16] = wdata_q[15:0];
                else           new_word[15:0]  = wdata_q[15:0];
            end
            3'b010:  new_word = wdata_q;
            default: store_ok = 1'b0;
        endcase
        if (trap) store_ok = 1'b0;
    end

    always_comb begin
        BUSYWAIT = 1'b0;
        case (state)
            IDLE:    BUSYWAIT = MEM_READ | MEM_WRITE;
            ACCESS:  BUSYWAIT = 1'b1;
            default: BUSYWAIT = 1'b0;
        endcase
        if (RESET) BUSYWAIT = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= IDLE;
            count     <= 4'd0;
            READ_DATA <= 32'h0;
`ifdef MISALIGN_TRAP_EN
            MISALIGNED <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (MEM_READ || MEM_WRITE) begin
                        addr_q  <= ADDRESS[AW+1:0];
                        wdata_q <= WRITE_DATA;
                        f3_q    <= FUNCT3;
                        wr_q    <= MEM_WRITE;
                        count   <= 4'(LATENCY - 1);
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (count == 4'd0) begin
                        state <= DONE;
                        if (!wr_q) READ_DATA <= load_data;
`ifdef MISALIGN_TRAP_EN
                        MISALIGNED <= trap;
`endif
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
`ifdef MISALIGN_TRAP_EN
                    MISALIGNED <= 1'b0;
`endif
                end
            endcase
        end
    end

    // Array is never reset; a reset during ACCESS simply blocks the commit.
    always_ff @(posedge CLK) begin
        if (!RESET && state == ACCESS && count == 4'd0 && wr_q && store_ok)
            mem[idx] <= new_word;
    end
endmodule

// File: tb/tb_data_memory.sv
// tb/tb_data_memory.sv - randomized bench for data_memory against a byte-array reference model
module tb_data_memory;
    localparam int DEPTH = 256;
    localparam int LAT   = 4;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [2:0]  FUNCT3;
    logic [31:0] ADDRESS;
    logic [31:0] WRITE_DATA;
    logic [31:0] READ_DATA;
    logic        BUSYWAIT;
`ifdef MISALIGN_TRAP_EN
    logic        MISALIGNED;
`endif

    int total = 0;
    int bad   = 0;

    logic [7:0]  mdl [DEPTH*4];
    logic [31:0] mdl_rdata;

    data_memory #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .CLK(CLK),
        .RESET(RESET),
        .MEM_READ(MEM_READ),
        .MEM_WRITE(MEM_WRITE),
        .FUNCT3(FUNCT3),
        .ADDRESS(ADDRESS),
        .WRITE_DATA(WRITE_DATA),
        .READ_DATA(READ_DATA),
        .BUSYWAIT(BUSYWAIT)
`ifdef MISALIGN_TRAP_EN
        ,
        .MISALIGNED(MISALIGNED)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic mdl_misaligned(input logic [2:0] f3, input logic [31:0] a);
`ifdef MISALIGN_TRAP_EN
        return ((f3[1:0] == 2'b01) && a[0]) || ((f3 == 3'b010) && (a[1:0] != 2'b00));
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] mdl_load(input logic [2:0] f3, input logic [31:0] a);
        int          b;
        int          h;
        int          w;
        logic [7:0]  by;
        logic [15:0] hw;
        logic [31:0] wd;
        b  = int'(a % (DEPTH * 4));
        h  = b - (b % 2);
        w  = b - (b % 4);
        by = mdl[b];
        hw = {mdl[h+1], mdl[h]};
        wd = {mdl[w+3], mdl[w+2], mdl[w+1], mdl[w]};
        if (mdl_misaligned(f3, a)) return 32'h0;
        case (f3)
            3'd0:    return {{24{by[7]}}, by};
            3'd1:    return {{16{hw[15]}}, hw};
            3'd2:    return wd;
            3'd4:    return {24'h0, by};
            3'd5:    return {16'h0, hw};
            default: return 32'h0;
        endcase
    endfunction

    task automatic mdl_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        int b;
        int h;
        int w;
        b = int'(a % (DEPTH * 4));
        h = b - (b % 2);
        w = b - (b % 4);
        if (mdl_misaligned(f3, a)) return;
        case (f3)
            3'd0: mdl[b] = d[7:0];
            3'd1: begin mdl[h] = d[7:0]; mdl[h+1] = d[15:8]; end
            3'd2: begin
                mdl[w] = d[7:0]; mdl[w+1] = d[15:8]; mdl[w+2] = d[23:16]; mdl[w+3] = d[31:24];
            end
            default: ;
        endcase
    endtask

    // One full request; inputs are scrambled while the request is in flight.
    task automatic run_op(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] d, input string tag);
        int busy;
        int guard;
        @(negedge CLK);
        MEM_READ = rd; MEM_WRITE = wr; FUNCT3 = f3; ADDRESS = a; WRITE_DATA = d;
        #1;
        busy = 0;
        guard = 0;
        while (BUSYWAIT === 1'b1 && guard < 40) begin
            busy++;
            guard++;
            @(posedge CLK);
            #1;
            MEM_READ = 1'($urandom); MEM_WRITE = 1'($urandom); FUNCT3 = 3'($urandom);
            ADDRESS = $urandom; WRITE_DATA = $urandom;
            @(negedge CLK);
        end
        if (wr) mdl_store(f3, a, d);
        else    mdl_rdata = mdl_load(f3, a);
        check({tag, "_busy"}, 32'(busy), 32'(LAT + 1));
        check({tag, "_rdata"}, READ_DATA, mdl_rdata);
`ifdef MISALIGN_TRAP_EN
        check({tag, "_mis"}, {31'h0, MISALIGNED}, {31'h0, mdl_misaligned(f3, a)});
`endif
        @(posedge CLK);
        #1;
        MEM_READ = 1'b0; MEM_WRITE = 1'b0;
    endtask

    initial begin
        RESET = 1'b1; MEM_READ = 1'b1; MEM_WRITE = 1'b0; FUNCT3 = 3'd2;
        ADDRESS = 32'h0; WRITE_DATA = 32'h0;
        mdl_rdata = 32'h0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_busy", {31'h0, BUSYWAIT}, 32'h0);
        check("rst_rdata", READ_DATA, 32'h0);
`ifdef MISALIGN_TRAP_EN
        check("rst_mis", {31'h0, MISALIGNED}, 32'h0);
`endif
        MEM_READ = 1'b0;
        @(posedge CLK);
        #1;
        RESET = 1'b0;

        for (int i = 0; i < DEPTH; i++)
            run_op(1'b0, 1'b1, 3'd2, 32'(i * 4), $urandom, "fill");

        run_op(1'b0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, "sw10");
        run_op(1'b1, 1'b0, 3'd2, 32'h10, 32'h0, "lw10");
        check("lw10_const", READ_DATA, 32'hDEADBEEF);
        run_op(1'b1, 1'b0, 3'd0, 32'h13, 32'h0, "lb13");
        check("lb13_const", READ_DATA, 32'hFFFFFFDE);
        run_op(1'b1, 1'b0, 3'd4, 32'h13, 32'h0, "lbu13");
        check("lbu13_const", READ_DATA, 32'h000000DE);
        run_op(1'b1, 1'b0, 3'd1, 32'h12, 32'h0, "lh12");
        check("lh12_const", READ_DATA, 32'hFFFFDEAD);
        run_op(1'b1, 1'b0, 3'd5, 32'h10, 32'h0, "lhu10");
        check("lhu10_const", READ_DATA, 32'h0000BEEF);
        run_op(1'b0, 1'b1, 3'd0, 32'h11, 32'h12, "sb11");
        check("sb11_hold", READ_DATA, 32'h0000BEEF);
        run_op(1'b1, 1'b0, 3'd2, 32'h10, 32'h0, "lw10b");
        check("lw10b_const", READ_DATA, 32'hDEAD12EF);

        run_op(1'b0, 1'b1, 3'd2, 32'h400, 32'hCAFEF00D, "sw400");
        run_op(1'b1, 1'b0, 3'd2, 32'h000, 32'h0, "lw0");
        check("wrap_const", READ_DATA, 32'hCAFEF00D);
        run_op(1'b1, 1'b1, 3'd2, 32'h8, 32'h5A5A5A5A, "both");
        run_op(1'b1, 1'b0, 3'd2, 32'h8, 32'h0, "lw8");
        check("both_const", READ_DATA, 32'h5A5A5A5A);
        run_op(1'b1, 1'b0, 3'd3, 32'h8, 32'h0, "lundef");
        check("lundef_const", READ_DATA, 32'h0);
        run_op(1'b0, 1'b1, 3'd6, 32'h8, 32'h77777777, "sundef");
        run_op(1'b1, 1'b0, 3'd2, 32'h8, 32'h0, "lw8b");
        check("sundef_const", READ_DATA, 32'h5A5A5A5A);

        run_op(1'b0, 1'b1, 3'd2, 32'h20, 32'h11111111, "sw20");
        run_op(1'b1, 1'b0, 3'd2, 32'h10, 32'h0, "lw10c");
        @(negedge CLK);
        MEM_WRITE = 1'b1; FUNCT3 = 3'd2; ADDRESS = 32'h20; WRITE_DATA = 32'h22222222;
        @(posedge CLK);
        #1;
        MEM_WRITE = 1'b0;
        @(posedge CLK);
        #1;
        RESET = 1'b1;
        #1;
        check("abort_busy", {31'h0, BUSYWAIT}, 32'h0);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        mdl_rdata = 32'h0;
        check("abort_rdata", READ_DATA, 32'h0);
        check("abort_busy2", {31'h0, BUSYWAIT}, 32'h0);
        run_op(1'b1, 1'b0, 3'd2, 32'h20, 32'h0, "lw20");
        check("abort_const", READ_DATA, 32'h11111111);

`ifdef MISALIGN_TRAP_EN
        run_op(1'b0, 1'b1, 3'd2, 32'h21, 32'h33333333, "swmis");
        run_op(1'b1, 1'b0, 3'd2, 32'h20, 32'h0, "lw20b");
        check("mis_const", READ_DATA, 32'h11111111);
`endif

        for (int i = 0; i < 300; i++) begin
            int k;
            k = int'($urandom_range(0, 2));
            run_op(k != 1, k != 0, 3'($urandom), $urandom, $urandom, "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
